qmem_cmd_master: RTL and testbench

// - QMEM bus initiator driving ctrl_regs-style responders (always-ack or slow-ack).
// - Accepts queued read/write commands from a control source (UART bridge, boot sequencer),

---
 rtl/qmem_pkg.sv | 26 ++
 rtl/qmem_cmd_fifo.sv | 48 ++++
 rtl/qmem_cmd_master.sv | 168 ++++++++++++++++
 tb/tb_qmem_cmd_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qmem_pkg.sv
// Shared definitions for the QMEM command master: bus width defaults,
// FSM state encoding and the layout of a queued command word.
package qmem_pkg;

    localparam int QAW_DEF = 22;
    localparam int QDW_DEF = 32;
    localparam int QSW_DEF = QDW_DEF / 8;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_RDAT_ENC = 2'd2;
    localparam logic [1:0] ST_RSP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE_ENC,
        S_REQ  = ST_REQ_ENC,
        S_RDAT = ST_RDAT_ENC,
        S_RSP  = ST_RSP_ENC
    } state_e;

    // A command word is packed as {we, sel, adr, dat}, MSB first.
    function automatic int cmdWidth(input int qaw, input int qdw, input int qsw);
        return 1 + qsw + qaw + qdw;
    endfunction

endpackage

// File: rtl/qmem_cmd_fifo.sv
// Single-clock command FIFO; the head entry is presented straight from the
// storage flops so the master can issue it the cycle it is popped.
module qmem_cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic          doPush;
    logic          doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // The extra pointer bit distinguishes a full FIFO from an empty one.
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign dout  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/qmem_cmd_master.sv
// QMEM bus initiator: queues read/write commands, issues them one at a time
// with an ack timeout, and returns exactly one response per command.
module qmem_cmd_master
    import qmem_pkg::*;
#(
    parameter int QAW = QAW_DEF,
    parameter int QDW = QDW_DEF,
    parameter int QSW = QDW / 8,
    parameter int CFD = 4,
    parameter int TMO = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_we,
    input  logic [QAW-1:0] cmd_adr,
    input  logic [QSW-1:0] cmd_sel,
    input  logic [QDW-1:0] cmd_dat,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_we,
    output logic [QDW-1:0] rsp_dat,
    output logic           rsp_err,
    output logic           busy,
    output logic [QAW-1:0] adr,
    output logic           cs,
    output logic           we,
    output logic [QSW-1:0] sel,
    output logic [QDW-1:0] dat_w,
    input  logic [QDW-1:0] dat_r,
    input  logic           ack,
    input  logic           err
);

    localparam int CW = cmdWidth(QAW, QDW, QSW);
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    localparam logic [TW-1:0] TMO_SAT  = '1;

    logic           fifoFull;
    logic           fifoEmpty;
    logic           fifoPush;
    logic           fifoPop;
    logic [CW-1:0]  fifoDin;
    logic [CW-1:0]  fifoDout;

    logic           headWe;
    logic [QSW-1:0] headSel;
    logic [QAW-1:0] headAdr;
    logic [QDW-1:0] headDat;

    state_e         state_q;
    logic [TW-1:0]  tmoCnt_q;
    logic           cs_q;
    logic           we_q;
    logic [QAW-1:0] adr_q;
    logic [QSW-1:0] sel_q;
    logic [QDW-1:0] datW_q;
    logic           rspValid_q;
    logic           rspWe_q;
    logic           rspErr_q;
    logic [QDW-1:0] rspDat_q;

    assign fifoDin  = {cmd_we, cmd_sel, cmd_adr, cmd_dat};
    assign fifoPush = cmd_valid && !fifoFull;
    assign fifoPop  = (state_q == S_IDLE) && !fifoEmpty;

    assign headDat = fifoDout[QDW-1:0];
    assign headAdr = fifoDout[QDW +: QAW];
    assign headSel = fifoDout[QDW+QAW +: QSW];
    assign headWe  = fifoDout[CW-1];

    qmem_cmd_fifo #(
        .DW    (CW),
        .DEPTH (CFD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (fifoDin),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .dout  (fifoDout)
    );

    assign cmd_ready = !fifoFull;
    assign busy      = !fifoEmpty || (state_q != S_IDLE);
    assign cs        = cs_q;
    assign we        = we_q;
    assign adr       = adr_q;
    assign sel       = sel_q;
    assign dat_w     = datW_q;
    assign rsp_valid = rspValid_q;
    assign rsp_we    = rspWe_q;
    assign rsp_err   = rspErr_q;
    assign rsp_dat   = rspDat_q;

    // Access sequencer. Every REQ exit drops cs, and RSP always returns through
    // IDLE, so two accesses are always separated by at least one idle bus cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmoCnt_q   <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            datW_q     <= '0;
            rspValid_q <= 1'b0;
            rspWe_q    <= 1'b0;
            rspErr_q   <= 1'b0;
            rspDat_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifoEmpty) begin
                        adr_q    <= headAdr;
                        sel_q    <= headSel;
                        we_q     <= headWe;
                        datW_q   <= headWe ? headDat : '0;
                        cs_q     <= 1'b1;
                        tmoCnt_q <= '0;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        cs_q    <= 1'b0;
                        rspWe_q <= we_q;
                        if (err || we_q) begin
                            rspErr_q   <= err;
                            rspDat_q   <= '0;
                            rspValid_q <= 1'b1;
                            state_q    <= S_RSP;
                        end else begin
                            state_q <= S_RDAT;
                        end
                    end else if ((TMO != 0) && (tmoCnt_q == TMO_LAST)) begin
                        cs_q       <= 1'b0;
                        rspWe_q    <= we_q;
                        rspErr_q   <= 1'b1;
                        rspDat_q   <= '0;
                        rspValid_q <= 1'b1;
                        state_q    <= S_RSP;
                    end else if (tmoCnt_q != TMO_SAT) begin
                        tmoCnt_q <= tmoCnt_q + 1'b1;
                    end
                end
                S_RDAT: begin
                    rspDat_q   <= dat_r;
                    rspErr_q   <= 1'b0;
                    rspValid_q <= 1'b1;
                    state_q    <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qmem_cmd_master.sv
// Directed bench for qmem_cmd_master: write/read latency, timeout, slow
// ack with error, backpressure ordering and reset in the middle of an access.
module tb_qmem_cmd_master;

    localparam int QAW = 22;
    localparam int QDW = 32;
    localparam int QSW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_we = 1'b0;
    logic [QAW-1:0] cmd_adr = '0;
    logic [QSW-1:0] cmd_sel = '0;
    logic [QDW-1:0] cmd_dat = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_we;
    logic [QDW-1:0] rsp_dat;
    logic           rsp_err;
    logic           busy;
    logic [QAW-1:0] adr;
    logic           cs;
    logic           we;
    logic [QSW-1:0] sel;
    logic [QDW-1:0] dat_w;
    logic [QDW-1:0] dat_r = '0;
    logic           ack = 1'b1;
    logic           err = 1'b0;

    int checks = 0;
    int errors = 0;
    int csSeen = 0;
    int rspSeen = 0;
    bit autoDatR = 1'b0;

    qmem_cmd_master #(
        .QAW (QAW),
        .QDW (QDW),
        .QSW (QSW),
        .CFD (4),
        .TMO (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_sel   (cmd_sel),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .adr       (adr),
        .cs        (cs),
        .we        (we),
        .sel       (sel),
        .dat_w     (dat_w),
        .dat_r     (dat_r),
        .ack       (ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [QAW-1:0] a, input logic [QSW-1:0] s, input logic [QDW-1:0] d);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_sel   = s;
        cmd_dat   = d;
    endtask

    // One cycle; the responder model optionally returns D0000000|adr while cs is up.
    task automatic stepCycle();
        @(negedge clk);
        cmd_valid = 1'b0;
        if (cs) begin
            csSeen++;
            if (autoDatR) dat_r = 32'hD000_0000 | {10'd0, adr};
        end
        if (rsp_valid) rspSeen++;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int n;
        int idx;
        logic           bpWe  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [QAW-1:0] bpAdr [5] = '{22'h200, 22'h204, 22'h208, 22'h20C, 22'h210};
        logic [QDW-1:0] bpDat [5] = '{32'h11, 32'h0, 32'h33, 32'h0, 32'h0};
        logic [QDW-1:0] bpExp [5] = '{32'h0, 32'hD000_0204, 32'h0, 32'hD000_020C, 32'hD000_0210};

        // Reset values
        #2;
        checkOutput("rst_cs", cs, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_adr", adr, 0);
        @(negedge clk);
        rst = 1'b0;
        stepCycle();

        // Single write: cs at N+2, response at N+3
        ack = 1'b1;
        applyStimulus(1'b1, 22'h04, 4'hF, 32'h1);
        stepCycle();
        checkOutput("wr_n1_cs", cs, 0);
        checkOutput("wr_n1_busy", busy, 1);
        stepCycle();
        checkOutput("wr_n2_cs", cs, 1);
        checkOutput("wr_n2_adr", adr, 22'h04);
        checkOutput("wr_n2_we", we, 1);
        checkOutput("wr_n2_sel", sel, 4'hF);
        checkOutput("wr_n2_datw", dat_w, 32'h1);
        checkOutput("wr_n2_rspv", rsp_valid, 0);
        stepCycle();
        checkOutput("wr_n3_cs", cs, 0);
        checkOutput("wr_n3_adr_hold", adr, 22'h04);
        checkOutput("wr_n3_rspv", rsp_valid, 1);
        checkOutput("wr_n3_err", rsp_err, 0);
        checkOutput("wr_n3_dat", rsp_dat, 0);
        checkOutput("wr_n3_we", rsp_we, 1);
        stepCycle();
        checkOutput("wr_n4_rspv", rsp_valid, 0);

        // Single read: dat_r valid only in the cycle after ack
        applyStimulus(1'b0, 22'h38, 4'hF, 32'hFFFF_FFFF);
        stepCycle();
        stepCycle();
        checkOutput("rd_n2_cs", cs, 1);
        checkOutput("rd_n2_we", we, 0);
        checkOutput("rd_n2_adr", adr, 22'h38);
        checkOutput("rd_n2_datw", dat_w, 0);
        stepCycle();
        checkOutput("rd_n3_rspv", rsp_valid, 0);
        dat_r = 32'h1234_5678;
        stepCycle();
        dat_r = 32'h0;
        checkOutput("rd_n4_rspv", rsp_valid, 1);
        checkOutput("rd_n4_dat", rsp_dat, 32'h1234_5678);
        checkOutput("rd_n4_err", rsp_err, 0);
        checkOutput("rd_n4_we", rsp_we, 0);
        stepCycle();

        // Timeout (TMO=8) followed by a queued command that completes
        ack = 1'b0;
        applyStimulus(1'b1, 22'h100, 4'h3, 32'hAA);
        stepCycle();
        applyStimulus(1'b1, 22'h104, 4'hC, 32'hBB);
        stepCycle();
        n = 0;
        while (cs && n < 40) begin
            n++;
            stepCycle();
        end
        checkOutput("tmo_cs_cycles", n, 8);
        checkOutput("tmo_rspv", rsp_valid, 1);
        checkOutput("tmo_err", rsp_err, 1);
        checkOutput("tmo_dat", rsp_dat, 0);
        ack = 1'b1;
        n = 0;
        while (!cs && n < 20) begin
            n++;
            stepCycle();
        end
        checkOutput("tmo_next_cs", cs, 1);
        checkOutput("tmo_next_adr", adr, 22'h104);
        checkOutput("tmo_next_datw", dat_w, 32'hBB);
        stepCycle();
        checkOutput("tmo_next_rspv", rsp_valid, 1);
        checkOutput("tmo_next_err", rsp_err, 0);
        stepCycle();

        // Slow ack with err on the fourth cs cycle of a read
        ack = 1'b0;
        dat_r = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 22'h20, 4'hF, 32'h0);
        stepCycle();
        n = 0;
        while (!cs && n < 20) begin
            n++;
            stepCycle();
        end
        n = 0;
        while (cs && n < 40) begin
            n++;
            if (n == 4) begin
                ack = 1'b1;
                err = 1'b1;
            end
            stepCycle();
        end
        ack = 1'b0;
        err = 1'b0;
        checkOutput("slow_cs_cycles", n, 4);
        checkOutput("slow_rspv", rsp_valid, 1);
        checkOutput("slow_err", rsp_err, 1);
        checkOutput("slow_dat", rsp_dat, 0);
        dat_r = 32'h0;
        stepCycle();

        // Backpressure: the head leaves the FIFO when issued, so 4 more fill it
        ack = 1'b1;
        rsp_ready = 1'b0;
        autoDatR = 1'b1;
        csSeen = 0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_ready_%0d", i), cmd_ready, 1);
            applyStimulus(bpWe[i], bpAdr[i], 4'hF, bpDat[i]);
            stepCycle();
        end
        checkOutput("bp_full", cmd_ready, 0);
        for (int i = 0; i < 6; i++) stepCycle();
        checkOutput("bp_single_access", csSeen, 1);
        checkOutput("bp_held_rspv", rsp_valid, 1);
        rsp_ready = 1'b1;
        idx = 0;
        n = 0;
        while (idx < 5 && n < 80) begin
            if (rsp_valid) begin
                checkOutput($sformatf("bp_we_%0d", idx), rsp_we, bpWe[idx]);
                checkOutput($sformatf("bp_dat_%0d", idx), rsp_dat, bpExp[idx]);
                checkOutput($sformatf("bp_err_%0d", idx), rsp_err, 0);
                idx++;
            end
            n++;
            stepCycle();
        end
        checkOutput("bp_rsp_count", idx, 5);
        stepCycle();
        checkOutput("bp_idle_busy", busy, 0);
        autoDatR = 1'b0;

        // Reset while an access is outstanding and two commands are queued
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 22'h300 + 22'(i * 4), 4'hF, 32'(i));
            stepCycle();
        end
        checkOutput("mid_pre_cs", cs, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_cs", cs, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_cmd_ready", cmd_ready, 1);
        csSeen = 0;
        rspSeen = 0;
        for (int i = 0; i < 8; i++) stepCycle();
        checkOutput("mid_no_access", csSeen, 0);
        checkOutput("mid_no_rsp", rspSeen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
